// File: rtl/br_pkg.sv
// Shared types and branch condition codes for the branch sequencer and its comparator.
package br_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

endpackage

// File: rtl/brc.sv
// Branch comparator: equality and signed/unsigned less-than on two operands.
module brc
  import br_pkg::*;
(
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic              br_unsigned,
  output logic              br_less,
  output logic              br_equal
);

  logic signed [DATA_W-1:0] w_rs1_s;
  logic signed [DATA_W-1:0] w_rs2_s;

  assign w_rs1_s  = rs1_data;
  assign w_rs2_s  = rs2_data;
  assign br_equal = (rs1_data == rs2_data);
  assign br_less  = br_unsigned ? (rs1_data < rs2_data) : (w_rs1_s < w_rs2_s);

endmodule

// File: rtl/br_seq.sv
// Branch resolution sequencer: accepts one branch/jump, resolves it over two
// cycles, then either redirects and flushes the pipeline or returns to idle.
module br_seq
  import br_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_br_valid,
  output logic              o_br_ready,
  input  logic              i_is_jump,
  input  logic [2:0]        i_funct3,
  input  logic [DATA_W-1:0] i_rs1_data,
  input  logic [DATA_W-1:0] i_rs2_data,
  input  logic [DATA_W-1:0] i_target,
  output logic              o_redirect,
  output logic [DATA_W-1:0] o_redirect_pc,
  output logic              o_flush,
  output logic              o_illegal,
  output logic [DATA_W-1:0] o_br_count,
  output logic [DATA_W-1:0] o_taken_count
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t            r_state;
  logic              r_ready;
  logic              r_phase;
  logic              r_redirect;
  logic              r_flush;
  logic              r_illegal;
  logic [3:0]        r_flush_cnt;
  logic [DATA_W-1:0] r_redirect_pc;
  logic [DATA_W-1:0] r_br_count;
  logic [DATA_W-1:0] r_taken_count;

  logic              r_is_jump_p0;
  logic [2:0]        r_funct3_p0;
  logic [DATA_W-1:0] r_rs1_p0;
  logic [DATA_W-1:0] r_rs2_p0;
  logic [DATA_W-1:0] r_target_p0;
  logic              r_taken_p1;
  logic              r_illegal_p1;

  logic              w_hs;
  logic              w_less;
  logic              w_equal;
  logic              w_taken;
  logic              w_illegal;

  assign w_hs = i_br_valid & r_ready;

  // p0: request capture on handshake
  always_ff @(posedge i_clk) begin
    if (w_hs) begin
      r_is_jump_p0 <= i_is_jump;
      r_funct3_p0  <= i_funct3;
      r_rs1_p0     <= i_rs1_data;
      r_rs2_p0     <= i_rs2_data;
      r_target_p0  <= i_target;
    end
  end

  brc u_brc (
    .rs1_data    (r_rs1_p0),
    .rs2_data    (r_rs2_p0),
    .br_unsigned (r_funct3_p0[1]),
    .br_less     (w_less),
    .br_equal    (w_equal)
  );

  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (r_funct3_p0)
      BEQ:     w_taken = w_equal;
      BNE:     w_taken = !w_equal;
      BLT:     w_taken = w_less;
      BGE:     w_taken = !w_less;
      BLTU:    w_taken = w_less;
      BGEU:    w_taken = !w_less;
      default: w_illegal = 1'b1;
    endcase
    if (r_is_jump_p0) begin
      w_taken   = 1'b1;
      w_illegal = 1'b0;
    end
  end

  // p1: registered decision, consumed on the second RESOLVE edge
  always_ff @(posedge i_clk) begin
    r_taken_p1   <= w_taken;
    r_illegal_p1 <= w_illegal;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_ready       <= 1'b0;
      r_phase       <= 1'b0;
      r_redirect    <= 1'b0;
      r_flush       <= 1'b0;
      r_illegal     <= 1'b0;
      r_flush_cnt   <= '0;
      r_redirect_pc <= '0;
      r_br_count    <= '0;
      r_taken_count <= '0;
    end else begin
      r_redirect <= 1'b0;
      r_illegal  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_ready <= 1'b0;
            r_phase <= 1'b0;
            r_state <= RESOLVE;
          end else begin
            r_ready <= 1'b1;
          end
        end
        RESOLVE: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
          end else begin
            r_phase    <= 1'b0;
            r_br_count <= sat_inc(r_br_count);
            if (r_taken_p1) begin
              r_taken_count <= sat_inc(r_taken_count);
              r_redirect    <= 1'b1;
              r_redirect_pc <= r_target_p0;
              r_flush       <= 1'b1;
              r_flush_cnt   <= FLUSH_LOAD;
              r_state       <= FLUSH;
            end else begin
              r_illegal <= r_illegal_p1;
              r_ready   <= 1'b1;
              r_state   <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (r_flush_cnt == 4'd0) begin
            r_flush <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign o_br_ready    = r_ready;
  assign o_redirect    = r_redirect;
  assign o_redirect_pc = r_redirect_pc;
  assign o_flush       = r_flush;
  assign o_illegal     = r_illegal;
  assign o_br_count    = r_br_count;
  assign o_taken_count = r_taken_count;

endmodule

// File: tb/tb_br_seq.sv
// Randomized bench for br_seq against a transaction-level model of branch outcome and timing.
module tb_br_seq;

  localparam int F = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_br_valid;
  logic        o_br_ready;
  logic        i_is_jump;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1_data, i_rs2_data, i_target;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_flush;
  logic        o_illegal;
  logic [31:0] o_br_count, o_taken_count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_br_cnt, m_tk_cnt, m_pc;

  br_seq #(.FLUSH_CYCLES(F)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_br_valid    (i_br_valid),
    .o_br_ready    (o_br_ready),
    .i_is_jump     (i_is_jump),
    .i_funct3      (i_funct3),
    .i_rs1_data    (i_rs1_data),
    .i_rs2_data    (i_rs2_data),
    .i_target      (i_target),
    .o_redirect    (o_redirect),
    .o_redirect_pc (o_redirect_pc),
    .o_flush       (o_flush),
    .o_illegal     (o_illegal),
    .o_br_count    (o_br_count),
    .o_taken_count (o_taken_count)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken(input bit j, input logic [2:0] f,
                                   input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (j) return 1'b1;
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] sat1(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Waits (bounded) for ready at a falling edge, then performs one handshake.
  task automatic issue(input bit j, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] t);
    int waited = 0;
    while (!o_br_ready && waited < 20) begin
      @(negedge i_clk);
      waited++;
    end
    if (!o_br_ready) chk("ready_timeout", 32'(o_br_ready), 32'd1);
    i_br_valid = 1'b1;
    i_is_jump  = j;
    i_funct3   = f;
    i_rs1_data = a;
    i_rs2_data = b;
    i_target   = t;
    @(posedge i_clk);
    #1;
    i_br_valid = 1'b0;
    i_is_jump  = 1'($urandom);
    i_funct3   = 3'($urandom);
    i_rs1_data = $urandom;
    i_rs2_data = $urandom;
    i_target   = $urandom;
  endtask

  task automatic run_req(input bit j, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] t);
    bit tk, ill;
    tk  = ref_taken(j, f, a, b);
    ill = !j && (f == 3'd2 || f == 3'd3);
    issue(j, f, a, b, t);
    @(negedge i_clk);
    chk("n0_ready", 32'(o_br_ready), 32'd0);
    chk("n0_redirect", 32'(o_redirect), 32'd0);
    @(negedge i_clk);
    chk("n1_redirect", 32'(o_redirect), 32'd0);
    chk("n1_illegal", 32'(o_illegal), 32'd0);
    chk("n1_ready", 32'(o_br_ready), 32'd0);
    @(negedge i_clk);
    m_br_cnt = sat1(m_br_cnt);
    if (tk) begin
      m_tk_cnt = sat1(m_tk_cnt);
      m_pc     = t;
    end
    chk("n2_redirect", 32'(o_redirect), 32'(tk));
    chk("n2_pc", o_redirect_pc, m_pc);
    chk("n2_flush", 32'(o_flush), 32'(tk));
    chk("n2_illegal", 32'(o_illegal), 32'(ill));
    chk("n2_ready", 32'(o_br_ready), 32'(!tk));
    chk("br_count", o_br_count, m_br_cnt);
    chk("taken_count", o_taken_count, m_tk_cnt);
    if (tk) begin
      for (int i = 1; i < F; i++) begin
        @(negedge i_clk);
        chk("fl_flush", 32'(o_flush), 32'd1);
        chk("fl_redirect", 32'(o_redirect), 32'd0);
        chk("fl_ready", 32'(o_br_ready), 32'd0);
      end
      @(negedge i_clk);
      chk("post_flush", 32'(o_flush), 32'd0);
      chk("post_ready", 32'(o_br_ready), 32'd1);
      chk("post_pc_hold", o_redirect_pc, m_pc);
      chk("post_illegal", 32'(o_illegal), 32'd0);
    end
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_br_valid = 1'b0;
    i_is_jump  = 1'b0;
    i_funct3   = 3'd0;
    i_rs1_data = '0;
    i_rs2_data = '0;
    i_target   = '0;
    m_br_cnt   = '0;
    m_tk_cnt   = '0;
    m_pc       = '0;

    repeat (3) @(negedge i_clk);
    chk("rst_ready", 32'(o_br_ready), 32'd0);
    chk("rst_flush", 32'(o_flush), 32'd0);
    chk("rst_redirect", 32'(o_redirect), 32'd0);
    chk("rst_pc", o_redirect_pc, 32'd0);
    chk("rst_brcnt", o_br_count, 32'd0);
    chk("rst_tkcnt", o_taken_count, 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rel_ready", 32'(o_br_ready), 32'd1);

    run_req(1'b0, 3'b000, 32'h5, 32'h5, 32'h100);
    run_req(1'b0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200);
    run_req(1'b0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h300);
    run_req(1'b0, 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h400);
    run_req(1'b0, 3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h500);
    run_req(1'b0, 3'b010, 32'h1, 32'h2, 32'h600);
    run_req(1'b1, 3'b010, 32'h1, 32'h2, 32'h700);
    run_req(1'b0, 3'b011, 32'h9, 32'h9, 32'h800);
    run_req(1'b0, 3'b001, 32'h9, 32'h9, 32'h900);

    for (int k = 0; k < 60; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'h8000_0000;
        default: b = $urandom;
      endcase
      run_req($urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), a, b, $urandom);
    end

    // Reset in the second flush cycle
    issue(1'b1, 3'b000, 32'h0, 32'h1, 32'hABC0);
    repeat (3) @(negedge i_clk);
    chk("mid_flush", 32'(o_flush), 32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    m_br_cnt = '0;
    m_tk_cnt = '0;
    m_pc     = '0;
    chk("ar_flush", 32'(o_flush), 32'd0);
    chk("ar_redirect", 32'(o_redirect), 32'd0);
    chk("ar_ready", 32'(o_br_ready), 32'd0);
    chk("ar_brcnt", o_br_count, 32'd0);
    chk("ar_tkcnt", o_taken_count, 32'd0);
    chk("ar_pc", o_redirect_pc, 32'd0);
    @(negedge i_clk);
    chk("ar_ready_held", 32'(o_br_ready), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("ar_rel_ready", 32'(o_br_ready), 32'd1);
    chk("ar_rel_flush", 32'(o_flush), 32'd0);
    chk("ar_rel_redirect", 32'(o_redirect), 32'd0);
    @(negedge i_clk);
    chk("ar_no_late_redirect", 32'(o_redirect), 32'd0);
    run_req(1'b0, 3'b000, 32'h7, 32'h7, 32'h1234);

    // Counter saturation
    force dut.r_br_count    = 32'hFFFF_FFFF;
    force dut.r_taken_count = 32'hFFFF_FFFF;
    @(negedge i_clk);
    release dut.r_br_count;
    release dut.r_taken_count;
    m_br_cnt = 32'hFFFF_FFFF;
    m_tk_cnt = 32'hFFFF_FFFF;
    chk("sat_preload", o_br_count, m_br_cnt);
    run_req(1'b0, 3'b000, 32'h5, 32'h5, 32'h100);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
